// File: rtl/alu_bcd_ctrl.sv
// rtl/alu_bcd_ctrl.sv - button-driven ALU with serial binary-to-BCD conversion and seven-segment display
//
// Ports:
//   clk, rst              : clock; synchronous active-high reset
//   a_in, b_in            : two's-complement operands (WIDTH bits)
//   btn_up, btn_down      : step the operation code up/down (asynchronous levels)
//   btn_go                : latch ALU result and start a decimal conversion (asynchronous level)
//   mode                  : current operation code
//   busy, valid           : conversion running / displayed value is valid
//   result, OF, CF, ZF, NF: registered result and flags
//   mode_seg, sign_seg    : active-low seven-segment drives for op code and sign
//   value_seg             : active-low seven-segment drives for the magnitude, digit 0 in [6:0]
module alu_bcd_ctrl #(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    a_in,
  input  logic [WIDTH-1:0]    b_in,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_go,
  output logic [2:0]          mode,
  output logic                busy,
  output logic                valid,
  output logic [WIDTH-1:0]    result,
  output logic                OF,
  output logic                CF,
  output logic                ZF,
  output logic                NF,
  output logic [6:0]          mode_seg,
  output logic [6:0]          sign_seg,
  output logic [7*NDIG-1:0]   value_seg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * NDIG;
  localparam logic [WIDTH-1:0] ONE_W   = 1;
  localparam logic [WIDTH:0]   ONE_W1  = 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t state_q, state_d;

  // Button synchronizers, bit order {go, down, up}
  logic [2:0] btn_raw, btn_s1, btn_s2, btn_prev, btn_pulse;
  logic       up_p, down_p, go_p;

  // ALU
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] neg_a, alu_res, alu_mag;
  logic             alu_of, alu_cf;

  // Double-dabble converter
  logic [WIDTH-1:0] bin_q;
  logic [BW-1:0]    bcd_q, bcd_adj;
  logic [CW-1:0]    cnt_q;

  // FSM control strobes
  logic go_load, mode_chg, shift_en, shift_last;
  logic lead_zero;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign btn_raw   = {btn_go, btn_down, btn_up};
  assign btn_pulse = btn_s2 & ~btn_prev;
  assign up_p      = btn_pulse[0];
  assign down_p    = btn_pulse[1];
  assign go_p      = btn_pulse[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
    end else begin
      btn_s1   <= btn_raw;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  // Combinational ALU on the live operands and current mode; sampled on go.
  always_comb begin
    add_sum = {1'b0, a_in} + {1'b0, b_in};
    sub_sum = {1'b0, a_in} + {1'b0, ~b_in} + ONE_W1;
    neg_a   = ~a_in + ONE_W;
    alu_res = '0;
    alu_of  = 1'b0;
    alu_cf  = 1'b0;
    case (mode)
      3'd0: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_cf  = add_sum[WIDTH];
        alu_of  = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (add_sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      3'd1: begin
        // Adder sees a and ~b, so "same sign" means a and b differ in sign.
        alu_res = sub_sum[WIDTH-1:0];
        alu_cf  = sub_sum[WIDTH];
        alu_of  = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sub_sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      3'd2: begin
        alu_res = neg_a;
        alu_of  = (a_in == MIN_NEG);
      end
      3'd3: alu_res = a_in & b_in;
      3'd4: alu_res = a_in | b_in;
      3'd5: alu_res = a_in ^ b_in;
      3'd6: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      default: alu_res = {{(WIDTH-1){1'b0}}, (a_in == b_in)};
    endcase
    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
    alu_mag = alu_res[WIDTH-1] ? (~alu_res + ONE_W) : alu_res;
  end

  // Add-3 correction ahead of each double-dabble shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    go_load    = 1'b0;
    mode_chg   = 1'b0;
    shift_en   = 1'b0;
    shift_last = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (go_p) begin
          go_load = 1'b1;
          state_d = CONV;
        end else if (up_p ^ down_p) begin
          mode_chg = 1'b1;
          state_d  = IDLE;
        end
      end
      CONV: begin
        // Button pulses are deliberately dropped here.
        shift_en = 1'b1;
        if (cnt_q == LAST_CNT) begin
          shift_last = 1'b1;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CONV);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode   <= '0;
      result <= '0;
      OF     <= 1'b0;
      CF     <= 1'b0;
      ZF     <= 1'b0;
      NF     <= 1'b0;
      valid  <= 1'b0;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (go_load) begin
        result <= alu_res;
        OF     <= alu_of;
        CF     <= alu_cf;
        ZF     <= (alu_res == '0);
        NF     <= alu_res[WIDTH-1];
        bin_q  <= alu_mag;
        bcd_q  <= '0;
        cnt_q  <= '0;
        valid  <= 1'b0;
      end
      if (mode_chg) begin
        mode  <= up_p ? mode + 3'd1 : mode - 3'd1;
        valid <= 1'b0;
      end
      if (shift_en) begin
        bcd_q <= BW'({bcd_adj, bin_q[WIDTH-1]});
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q + 1'b1;
        if (shift_last) valid <= 1'b1;
      end
    end
  end

  assign mode_seg = seg7({1'b0, mode});
  assign sign_seg = (valid && NF) ? 7'b0111111 : 7'b1111111;

  // Blank leading zeros from the top digit down; digit 0 is always lit.
  always_comb begin
    value_seg = '1;
    lead_zero = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if ((bcd_q[i*4 +: 4] != 4'd0) || (i == 0)) lead_zero = 1'b0;
      if (valid && !lead_zero) value_seg[i*7 +: 7] = seg7(bcd_q[i*4 +: 4]);
    end
  end

endmodule

// File: tb/tb_alu_bcd_ctrl.sv
// tb/tb_alu_bcd_ctrl.sv - scoreboard bench for alu_bcd_ctrl (WIDTH=8, NDIG=3)
module tb_alu_bcd_ctrl;

  localparam int WIDTH = 8;
  localparam int NDIG  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  a_in, b_in;
  logic              btn_up, btn_down, btn_go;
  logic [2:0]        mode;
  logic              busy, valid;
  logic [WIDTH-1:0]  result;
  logic              OF, CF, ZF, NF;
  logic [6:0]        mode_seg, sign_seg;
  logic [7*NDIG-1:0] value_seg;

  typedef struct {
    logic [7:0]  res;
    logic        of_f, cf_f, zf_f, nf_f;
    logic [6:0]  sign;
    logic [20:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tb_mode = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  alu_bcd_ctrl #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_go(btn_go),
    .mode(mode), .busy(busy), .valid(valid), .result(result),
    .OF(OF), .CF(CF), .ZF(ZF), .NF(NF),
    .mode_seg(mode_seg), .sign_seg(sign_seg), .value_seg(value_seg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic exp_t model(input int op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb, ua, ub, r, sv, mag;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    e.of_f = 1'b0;
    e.cf_f = 1'b0;
    case (op)
      0: begin r = sa + sb; e.res = 8'(r); e.of_f = (r > 127) || (r < -128); e.cf_f = (ua + ub) > 255; end
      1: begin r = sa - sb; e.res = 8'(r); e.of_f = (r > 127) || (r < -128); e.cf_f = (ua >= ub); end
      2: begin r = -sa; e.res = 8'(r); e.of_f = (sa == -128); end
      3: e.res = a & b;
      4: e.res = a | b;
      5: e.res = a ^ b;
      6: e.res = (sa < sb) ? 8'd1 : 8'd0;
      default: e.res = (a == b) ? 8'd1 : 8'd0;
    endcase
    e.zf_f = (e.res == 8'd0);
    e.nf_f = e.res[7];
    sv  = int'($signed(e.res));
    mag = (sv < 0) ? -sv : sv;
    e.sign = e.nf_f ? MINUS : BLANK;
    e.val[6:0]   = dig(mag % 10);
    e.val[13:7]  = (mag >= 10)  ? dig((mag / 10) % 10) : BLANK;
    e.val[20:14] = (mag >= 100) ? dig(mag / 100) : BLANK;
    return e;
  endfunction

  task automatic press(input logic up, input logic dn);
    btn_up = up;
    btn_down = dn;
    repeat (3) tick();
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (4) tick();
  endtask

  task automatic set_mode(input int m);
    while (tb_mode != m) begin
      press(1'b1, 1'b0);
      tb_mode = (tb_mode + 1) % 8;
    end
    n_cmp++; if (mode !== 3'(tb_mode)) begin n_bad++; $display("FAIL set_mode: mode=%0d required %0d", mode, tb_mode); end
  endtask

  // Press go with the given operands, check edge-3 latch and valid latency, then pop and compare.
  task automatic do_go(input string nm, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int k;
    sb_q.push_back(model(tb_mode, a, b));
    a_in = a;
    b_in = b;
    btn_go = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_edge3: busy=%b required 1", nm, busy); end
    n_cmp++; if (result !== sb_q[0].res) begin n_bad++; $display("FAIL %s result_edge3: result=%h required %h", nm, result, sb_q[0].res); end
    btn_go = 1'b0;
    k = 3;
    while (!valid && k < 40) begin tick(); k++; end
    n_cmp++; if (k !== WIDTH + 3) begin n_bad++; $display("FAIL %s valid_edge: valid at edge %0d required %0d", nm, k, WIDTH + 3); end
    e = sb_q.pop_front();
    n_cmp++; if (result !== e.res) begin n_bad++; $display("FAIL %s result: %h required %h", nm, result, e.res); end
    n_cmp++; if ({OF, CF, ZF, NF} !== {e.of_f, e.cf_f, e.zf_f, e.nf_f}) begin n_bad++; $display("FAIL %s flags OF,CF,ZF,NF: %b required %b", nm, {OF, CF, ZF, NF}, {e.of_f, e.cf_f, e.zf_f, e.nf_f}); end
    n_cmp++; if (sign_seg !== e.sign) begin n_bad++; $display("FAIL %s sign_seg: %b required %b", nm, sign_seg, e.sign); end
    n_cmp++; if (value_seg !== e.val) begin n_bad++; $display("FAIL %s value_seg: %b required %b", nm, value_seg, e.val); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_done: busy=%b required 0", nm, busy); end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; a_in = '0; b_in = '0; btn_up = 0; btn_down = 0; btn_go = 0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (mode !== 3'd0) begin n_bad++; $display("FAIL reset_mode: %0d required 0", mode); end
    n_cmp++; if ({busy, valid} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_valid: %b required 00", {busy, valid}); end
    n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL reset_result: %h required 00", result); end
    n_cmp++; if ({OF, CF, ZF, NF} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: %b required 0000", {OF, CF, ZF, NF}); end
    n_cmp++; if (mode_seg !== 7'b1000000) begin n_bad++; $display("FAIL reset_mode_seg: %b required 1000000", mode_seg); end
    n_cmp++; if ({sign_seg, value_seg} !== {28{1'b1}}) begin n_bad++; $display("FAIL reset_segs: %b %b required all ones", sign_seg, value_seg); end
    tb_mode = 0;
  endtask

  task automatic test_mode();
    btn_down = 1'b1;
    tick();
    tick();
    n_cmp++; if (mode !== 3'd0) begin n_bad++; $display("FAIL down_edge2: mode=%0d required 0", mode); end
    tick();
    n_cmp++; if (mode !== 3'd7) begin n_bad++; $display("FAIL down_wrap: mode=%0d required 7", mode); end
    n_cmp++; if (mode_seg !== 7'b1111000) begin n_bad++; $display("FAIL mode_seg7: %b required 1111000", mode_seg); end
    btn_down = 1'b0;
    repeat (4) tick();
    press(1'b1, 1'b0);
    n_cmp++; if (mode !== 3'd0) begin n_bad++; $display("FAIL up_wrap: mode=%0d required 0", mode); end
    press(1'b1, 1'b1);
    n_cmp++; if (mode !== 3'd0) begin n_bad++; $display("FAIL up_down_same: mode=%0d required 0", mode); end
    tb_mode = 0;
  endtask

  task automatic test_vectors();
    set_mode(0); do_go("add_100_50", 8'd100, 8'd50);
    set_mode(1); do_go("sub_5_5", 8'd5, 8'd5);
    set_mode(2); do_go("neg_min", 8'h80, 8'h00);
    set_mode(6); do_go("lt_neg", 8'hF0, 8'h05);
    set_mode(7); do_go("eq_same", 8'h3C, 8'h3C);
  endtask

  task automatic test_mode_clear();
    logic [7:0] held;
    held = result;
    btn_up = 1'b1;
    repeat (3) tick();
    btn_up = 1'b0;
    tb_mode = (tb_mode + 1) % 8;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL mode_clear_valid: %b required 0", valid); end
    n_cmp++; if (result !== held) begin n_bad++; $display("FAIL mode_clear_result: %h required %h", result, held); end
    n_cmp++; if (mode !== 3'(tb_mode)) begin n_bad++; $display("FAIL mode_clear_mode: %0d required %0d", mode, tb_mode); end
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int k;
    set_mode(0);
    e = model(0, 8'd20, 8'd30);
    sb_q.push_back(e);
    a_in = 8'd20; b_in = 8'd30;
    btn_go = 1'b1;
    repeat (3) tick();
    btn_go = 1'b0;
    tick();
    btn_go = 1'b1; btn_up = 1'b1; a_in = 8'd99;
    k = 4;
    while (!valid && k < 40) begin tick(); k++; end
    n_cmp++; if (k !== WIDTH + 3) begin n_bad++; $display("FAIL b2b_valid_edge: %0d required %0d", k, WIDTH + 3); end
    e = sb_q.pop_front();
    n_cmp++; if (result !== e.res) begin n_bad++; $display("FAIL b2b_result: %h required %h", result, e.res); end
    n_cmp++; if (value_seg !== e.val) begin n_bad++; $display("FAIL b2b_value_seg: %b required %b", value_seg, e.val); end
    btn_go = 1'b0; btn_up = 1'b0;
    repeat (6) tick();
    n_cmp++; if ({valid, busy} !== 2'b10) begin n_bad++; $display("FAIL b2b_no_requeue: valid,busy=%b required 10", {valid, busy}); end
    n_cmp++; if (mode !== 3'd0) begin n_bad++; $display("FAIL b2b_mode: %0d required 0", mode); end
  endtask

  task automatic test_reset_mid();
    set_mode(3);
    a_in = 8'h0F; b_in = 8'h3C;
    btn_go = 1'b1;
    repeat (5) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_edge5: %b required 1", busy); end
    n_cmp++; if (result !== 8'h0C) begin n_bad++; $display("FAIL rstmid_result_pre: %h required 0c", result); end
    rst = 1'b1; btn_go = 1'b0;
    tick();
    rst = 1'b0;
    tb_mode = 0;
    n_cmp++; if ({mode, busy, valid} !== 5'b00000) begin n_bad++; $display("FAIL rstmid_state: mode,busy,valid=%b required 00000", {mode, busy, valid}); end
    n_cmp++; if ({result, OF, CF, ZF, NF} !== 12'h000) begin n_bad++; $display("FAIL rstmid_result_flags: %h required 000", {result, OF, CF, ZF, NF}); end
    n_cmp++; if ({mode_seg, sign_seg, value_seg} !== {7'b1000000, {28{1'b1}}}) begin n_bad++; $display("FAIL rstmid_segs: %b required %b", {mode_seg, sign_seg, value_seg}, {7'b1000000, {28{1'b1}}}); end
    repeat (12) tick();
    n_cmp++; if ({busy, valid} !== 2'b00) begin n_bad++; $display("FAIL rstmid_stays_idle: %b required 00", {busy, valid}); end
  endtask

  task automatic test_hold_through_reset();
    btn_up = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++; if (mode !== 3'd0) begin n_bad++; $display("FAIL hold_early: mode=%0d required 0", mode); end
    tick();
    n_cmp++; if (mode !== 3'd1) begin n_bad++; $display("FAIL hold_pulse: mode=%0d required 1", mode); end
    repeat (4) tick();
    n_cmp++; if (mode !== 3'd1) begin n_bad++; $display("FAIL hold_single: mode=%0d required 1", mode); end
    btn_up = 1'b0;
    repeat (4) tick();
    tb_mode = 1;
  endtask

  task automatic test_random();
    int op;
    logic [7:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = $urandom_range(0, 7);
      a = 8'($urandom);
      b = (i % 4 == 3) ? a : 8'($urandom);
      set_mode(op);
      do_go("random", a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mode();
    test_vectors();
    test_mode_clear();
    test_back_to_back();
    test_reset_mid();
    test_hold_through_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_bcd_ctrl.md
ALU_BCD_CTRL -- requirements
Module: alu_bcd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 4..16).
REQ-002 SHALL have parameter NDIG, default 3, number of decimal magnitude digits (>= digits needed for 2^(WIDTH-1)).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a_in, b_in  input  WIDTH  two's-complement operands.
REQ-006 SHALL have ports btn_up, btn_down, btn_go  input  1  asynchronous level buttons.
REQ-007 SHALL have port mode  output  3  current operation code.
REQ-008 SHALL have ports busy, valid  output  1  conversion in progress / display result valid.
REQ-009 SHALL have port result  output  WIDTH  registered two's-complement result.
REQ-010 SHALL have ports OF, CF, ZF, NF  output  1  registered overflow, carry, zero, negative flags.
REQ-011 SHALL have ports mode_seg 7, sign_seg 7, value_seg 7*NDIG  output  active-low seven-segment drives (digit 0 in bits [6:0]).

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer plus previous-value register; an internal one-cycle pulse = sync2 & ~prev.
REQ-013 Ops SHALL be: 0 add, 1 sub (a + ~b + 1), 2 neg a, 3 and, 4 or, 5 xor, 6 signed a<b (result 1/0), 7 a==b (result 1/0).
REQ-014 Add/sub: CF = carry out of bit WIDTH-1; OF = operands-to-adder same sign and sum sign differs; other ops SHALL give CF=0.
REQ-015 Neg: OF=1 only when a_in = -2^(WIDTH-1) (result equals a_in); ops 3..7 SHALL give OF=0.
REQ-016 ZF = (result==0), NF = result[WIDTH-1], for all ops.
REQ-017 FSM states IDLE, CONV, DONE; reset state IDLE.
REQ-018 IDLE or DONE + go pulse: latch result and flags at that edge, load |result| (unsigned WIDTH bits, -2^(WIDTH-1) -> 2^(WIDTH-1)) into double-dabble shifter, clear BCD, valid<=0, enter CONV.
REQ-019 CONV: exactly WIDTH shift cycles, add-3 to every BCD nibble >=5 before each shift; on last shift enter DONE, valid<=1.
REQ-020 busy SHALL be 1 exactly while in CONV.
REQ-021 Timing: btn_go first sampled high at edge 1 -> result/flags updated at edge 3, valid high after edge WIDTH+3.
REQ-022 go, up, down pulses during CONV SHALL be ignored (no queuing).
REQ-023 up pulse: mode+1 mod 8; down: mode-1 mod 8 (0->7); up and down pulse same cycle: no change.
REQ-024 Mode change in IDLE/DONE SHALL clear valid and return to IDLE; result/flags hold.
REQ-025 mode_seg SHALL always show mode as digit 0..7.
REQ-026 When valid=0, sign_seg and all value_seg digits SHALL be blank (7'b1111111).
REQ-027 When valid=1: sign_seg = minus (7'b0111111) if NF else blank; value_seg = BCD magnitude, leading zeros blanked, digit 0 always shown.
REQ-028 Digit encodings 0-9 active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-029 rst=1 at an edge SHALL set state IDLE, mode=0, result=0, OF=CF=ZF=NF=0, busy=0, valid=0, BCD=0, sync/prev regs=0, in any state including mid-CONV.
REQ-030 Button held high through reset release SHALL NOT produce a pulse until released and pressed again... only if prev already 1; prev reset to 0 means a held button yields one pulse after release of rst.

Verification (WIDTH=8, NDIG=3)
REQ-031 mode 0, a=100, b=50, go -> result 0x96, OF=1, CF=0, NF=1, ZF=0; after edge 11 valid=1, display "-106".
REQ-032 mode 1, a=5, b=5, go -> result 0, ZF=1, CF=1, OF=0; display blank,blank,"0", sign blank.
REQ-033 mode 2, a=-128, go -> result 0x80, OF=1, NF=1; display "-128".
REQ-034 after reset, down pulse -> mode 7 after edge 3; up pulse -> mode 0; simultaneous up+down -> mode unchanged.
REQ-035 go, then second go and up during CONV -> ignored: valid at edge 11, mode unchanged, result from first go.
REQ-036 rst asserted at edge 6 of a conversion -> next cycle all outputs at reset values, segments blank except mode_seg "0".
